// File: rtl/mesh_router_xy.sv
// Buffered 5-port XY mesh router.
// Per-port, per-VC input FIFOs feed one registered output slot per port. Each
// output slot is filled by round-robin arbitration over all FIFO heads that
// route to it. Port map: 0 local, 1 north (+Y), 2 east (+X), 3 south (-Y),
// 4 west (-X).

// One input VC queue; count is kept one bit wider than the pointers so that
// full and empty can be told apart.
module mesh_router_xy_vcq #(
    parameter int DATA_W = 35,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] head,
    output logic              not_empty,
    output logic              not_full
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;

    assign head      = mem[rd_ptr];
    assign not_empty = (count != '0);
    assign not_full  = (count != (AW+1)'(DEPTH));

    // Storage needs no reset; only occupancy is reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    // Pointer and occupancy bookkeeping. Pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

module mesh_router_xy #(
    parameter  int DATA_W  = 35,
    parameter  int NUM_VC  = 2,
    parameter  int DEPTH   = 4,
    parameter  int COORD_W = 2,
    localparam int VCW     = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input  logic                 clk,
    input  logic                 RST_,
    input  logic [COORD_W-1:0]   MY_XPOS,
    input  logic [COORD_W-1:0]   MY_YPOS,
    input  logic [5*DATA_W-1:0]  IDATA,
    input  logic [4:0]           IVALID,
    input  logic [5*VCW-1:0]     IVCH,
    output logic [5*NUM_VC-1:0]  ORDY,
    output logic [4:0]           ODROP,
    output logic [5*DATA_W-1:0]  ODATA,
    output logic [4:0]           OVALID,
    output logic [5*VCW-1:0]     OVCH,
    input  logic [5*NUM_VC-1:0]  IRDY
);
    localparam int NP = 5;
    localparam int NQ = NP * NUM_VC;
    localparam int QW = $clog2(NQ);

    logic [NQ-1:0]             q_push;
    logic [NQ-1:0]             q_pop;
    logic [NQ-1:0]             q_nempty;
    logic [NQ-1:0]             q_nfull;
    logic [NQ-1:0][DATA_W-1:0] q_head;
    logic [NQ-1:0][2:0]        q_route;

    logic [NP-1:0][QW-1:0]     rr_ptr;
    logic [NP-1:0][QW-1:0]     win;
    logic [NP-1:0]             gnt;
    logic [NP-1:0]             can_load;
    logic [NP-1:0]             drop;

    assign ORDY = q_nfull;

    // Queue array: q = port*NUM_VC + vc. Each queue decodes its own push and
    // computes the XY output port of its head flit.
    for (genvar q = 0; q < NQ; q++) begin : g_q
        localparam int P = q / NUM_VC;
        localparam int V = q % NUM_VC;
        logic [COORD_W-1:0] dx;
        logic [COORD_W-1:0] dy;

        assign q_push[q] = IVALID[P] && (IVCH[P*VCW +: VCW] == VCW'(V)) && q_nfull[q];

        mesh_router_xy_vcq #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_vcq (
            .clk       (clk),
            .rst       (RST_),
            .push      (q_push[q]),
            .pop       (q_pop[q]),
            .wdata     (IDATA[P*DATA_W +: DATA_W]),
            .head      (q_head[q]),
            .not_empty (q_nempty[q]),
            .not_full  (q_nfull[q])
        );

        assign dx = q_head[q][DATA_W-1 -: COORD_W];
        assign dy = q_head[q][DATA_W-COORD_W-1 -: COORD_W];
        // X first, then Y, then local; a U-turn is allowed.
        assign q_route[q] = (dx > MY_XPOS) ? 3'd2 :
                            (dx < MY_XPOS) ? 3'd4 :
                            (dy > MY_YPOS) ? 3'd1 :
                            (dy < MY_YPOS) ? 3'd3 : 3'd0;
    end

    // Per-port drop detect and output-slot load enable.
    for (genvar p = 0; p < NP; p++) begin : g_p
        logic [NUM_VC-1:0] irdy_p;
        // An invalid VC id or a full VC both leave the flit unaccepted.
        assign drop[p]     = IVALID[p] && !(|q_push[p*NUM_VC +: NUM_VC]);
        assign irdy_p      = IRDY[p*NUM_VC +: NUM_VC];
        assign can_load[p] = !OVALID[p] || irdy_p[OVCH[p*VCW +: VCW]];
    end

    // Round-robin per output: first requesting head at or after rr_ptr wins.
    // A head requests only its routed output, so pops never collide.
    always_comb begin
        int idx;
        idx   = 0;
        gnt   = '0;
        win   = '0;
        q_pop = '0;
        for (int o = 0; o < NP; o++) begin
            for (int k = 0; k < NQ; k++) begin
                idx = int'(rr_ptr[o]) + k;
                if (idx >= NQ) idx = idx - NQ;
                if (can_load[o] && !gnt[o] && q_nempty[idx] && (q_route[idx] == 3'(o))) begin
                    gnt[o] = 1'b1;
                    win[o] = QW'(idx);
                end
            end
            if (gnt[o]) q_pop[win[o]] = 1'b1;
        end
    end

    // Output slots, RR pointers and the registered drop pulse.
    always_ff @(posedge clk or posedge RST_) begin
        if (RST_) begin
            ODATA  <= '0;
            OVALID <= '0;
            OVCH   <= '0;
            ODROP  <= '0;
            rr_ptr <= '0;
        end else begin
            ODROP <= drop;
            for (int o = 0; o < NP; o++) begin
                if (gnt[o]) begin
                    ODATA[o*DATA_W +: DATA_W] <= q_head[win[o]];
                    OVCH[o*VCW +: VCW]        <= VCW'(int'(win[o]) % NUM_VC);
                    OVALID[o]                 <= 1'b1;
                    rr_ptr[o]                 <= (int'(win[o]) == NQ - 1) ? '0 : win[o] + 1'b1;
                end else if (OVALID[o] && can_load[o]) begin
                    OVALID[o] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_mesh_router_xy.sv
// Bench for mesh_router_xy: directed scenarios with literal expectations plus
// random traffic, all checked every cycle against a queue-based model.
module tb_mesh_router_xy;
    localparam int DATA_W  = 35;
    localparam int NUM_VC  = 2;
    localparam int DEPTH   = 4;
    localparam int COORD_W = 2;
    localparam int VCW     = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
    localparam int NP      = 5;
    localparam int NQ      = NP * NUM_VC;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [COORD_W-1:0]    my_x = 2'd1;
    logic [COORD_W-1:0]    my_y = 2'd1;
    logic [NP*DATA_W-1:0]  idata = '0;
    logic [NP-1:0]         ivalid = '0;
    logic [NP*VCW-1:0]     ivch = '0;
    logic [NQ-1:0]         ordy;
    logic [NP-1:0]         odrop;
    logic [NP*DATA_W-1:0]  odata;
    logic [NP-1:0]         ovalid;
    logic [NP*VCW-1:0]     ovch;
    logic [NQ-1:0]         irdy = '1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mesh_router_xy #(
        .DATA_W (DATA_W), .NUM_VC (NUM_VC), .DEPTH (DEPTH), .COORD_W (COORD_W)
    ) dut (
        .clk (clk), .RST_ (rst), .MY_XPOS (my_x), .MY_YPOS (my_y),
        .IDATA (idata), .IVALID (ivalid), .IVCH (ivch), .ORDY (ordy),
        .ODROP (odrop), .ODATA (odata), .OVALID (ovalid), .OVCH (ovch), .IRDY (irdy)
    );

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] mq [NQ][$];
    logic [NP-1:0]     m_val;
    logic [NP-1:0]     m_drop;
    logic [DATA_W-1:0] m_data [NP];
    int                m_vc   [NP];
    int                m_ptr  [NP];

    function automatic int route_of(logic [DATA_W-1:0] f);
        int dx, dy;
        dx = int'(f[DATA_W-1 -: COORD_W]);
        dy = int'(f[DATA_W-COORD_W-1 -: COORD_W]);
        if (dx > int'(my_x)) return 2;
        if (dx < int'(my_x)) return 4;
        if (dy > int'(my_y)) return 1;
        if (dy < int'(my_y)) return 3;
        return 0;
    endfunction

    task automatic model_reset();
        for (int q = 0; q < NQ; q++) mq[q].delete();
        m_val  = '0;
        m_drop = '0;
        for (int o = 0; o < NP; o++) begin
            m_data[o] = '0; m_vc[o] = 0; m_ptr[o] = 0;
        end
    endtask

    task automatic model_step();
        bit g [NP];
        int w [NP];
        bit acc [NP];
        int pv [NP];
        int r;
        for (int o = 0; o < NP; o++) begin
            g[o] = 1'b0; w[o] = 0;
            if (!m_val[o] || irdy[o*NUM_VC + m_vc[o]]) begin
                for (int k = 0; k < NQ; k++) begin
                    r = (m_ptr[o] + k) % NQ;
                    if (!g[o] && mq[r].size() > 0 && route_of(mq[r][0]) == o) begin
                        g[o] = 1'b1; w[o] = r;
                    end
                end
            end
        end
        for (int p = 0; p < NP; p++) begin
            pv[p]  = int'(ivch[p*VCW +: VCW]);
            acc[p] = 1'b0;
            if (ivalid[p] && pv[p] < NUM_VC) acc[p] = (mq[p*NUM_VC + pv[p]].size() < DEPTH);
            m_drop[p] = ivalid[p] && !acc[p];
        end
        for (int o = 0; o < NP; o++) begin
            if (g[o]) begin
                m_data[o] = mq[w[o]].pop_front();
                m_vc[o]   = w[o] % NUM_VC;
                m_val[o]  = 1'b1;
                m_ptr[o]  = (w[o] + 1) % NQ;
            end else if (m_val[o] && irdy[o*NUM_VC + m_vc[o]]) begin
                m_val[o] = 1'b0;
            end
        end
        for (int p = 0; p < NP; p++)
            if (acc[p]) mq[p*NUM_VC + pv[p]].push_back(idata[p*DATA_W +: DATA_W]);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [NQ-1:0] e_rdy;
        if (!rst) begin
            for (int q = 0; q < NQ; q++) e_rdy[q] = (mq[q].size() < DEPTH);
            checks++;
            if (ovalid !== m_val) begin
                errors++; $display("FAIL ovalid t=%0t act=%b exp=%b", $time, ovalid, m_val);
            end
            checks++;
            if (odrop !== m_drop) begin
                errors++; $display("FAIL odrop t=%0t act=%b exp=%b", $time, odrop, m_drop);
            end
            checks++;
            if (ordy !== e_rdy) begin
                errors++; $display("FAIL ordy t=%0t act=%b exp=%b", $time, ordy, e_rdy);
            end
            for (int o = 0; o < NP; o++) begin
                if (m_val[o]) begin
                    checks++;
                    if (odata[o*DATA_W +: DATA_W] !== m_data[o] || ovch[o*VCW +: VCW] !== VCW'(m_vc[o])) begin
                        errors++;
                        $display("FAIL out_flit port=%0d t=%0t act=%h/vc%0d exp=%h/vc%0d", o, $time,
                                 odata[o*DATA_W +: DATA_W], ovch[o*VCW +: VCW], m_data[o], m_vc[o]);
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t act=%0h exp=%0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] mk(int dx, int dy, int pl);
        logic [DATA_W-1:0] f;
        f = '0;
        f[DATA_W-1 -: COORD_W]          = COORD_W'(dx);
        f[DATA_W-COORD_W-1 -: COORD_W]  = COORD_W'(dy);
        f[DATA_W-2*COORD_W-1:0]         = (DATA_W-2*COORD_W)'(pl);
        return f;
    endfunction

    task automatic send(int p, int vc, logic [DATA_W-1:0] f);
        ivalid[p]                 = 1'b1;
        ivch[p*VCW +: VCW]        = VCW'(vc);
        idata[p*DATA_W +: DATA_W] = f;
    endtask

    task automatic rand_cycle();
        for (int p = 0; p < NP; p++) begin
            if ($urandom_range(0, 99) < 40)
                send(p, int'($urandom_range(0, NUM_VC-1)),
                     mk(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom)));
            else
                ivalid[p] = 1'b0;
        end
        for (int q = 0; q < NQ; q++) irdy[q] = ($urandom_range(0, 99) < 75);
        tick();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        repeat (3) tick();
        rst = 1'b0;
        chk("reset_ovalid", 64'(ovalid), 64'(0));
        chk("reset_odrop",  64'(odrop),  64'(0));
        chk("reset_ordy",   64'(ordy),   64'({NQ{1'b1}}));
        chk("reset_odata",  64'(odata[63:0]), 64'(0));
        tick();

        // Routing from the local port with MY=(1,1): east, south, local.
        send(0, 1, mk(2, 1, 'h101)); tick(); ivalid = '0;
        chk("route_e_not_yet", 64'(ovalid), 64'(0));
        tick();
        chk("route_e_valid", 64'(ovalid), 64'(5'b00100));
        chk("route_e_data",  64'(odata[2*DATA_W +: DATA_W]), 64'(mk(2, 1, 'h101)));
        chk("route_e_vc",    64'(ovch[2*VCW +: VCW]), 64'(1));
        chk("route_e_model", 64'(m_val), 64'(5'b00100));
        tick();
        send(0, 1, mk(1, 0, 'h102)); tick(); ivalid = '0; tick();
        chk("route_s_valid", 64'(ovalid), 64'(5'b01000));
        chk("route_s_data",  64'(odata[3*DATA_W +: DATA_W]), 64'(mk(1, 0, 'h102)));
        tick();
        send(0, 1, mk(1, 1, 'h103)); tick(); ivalid = '0; tick();
        chk("route_l_valid", 64'(ovalid), 64'(5'b00001));
        chk("route_l_data",  64'(odata[0 +: DATA_W]), 64'(mk(1, 1, 'h103)));
        chk("route_l_vc",    64'(ovch[0 +: VCW]), 64'(1));
        tick();

        // Contention on the local output: two bursts, each must leave 1,2,3.
        for (int b = 0; b < 2; b++) begin
            send(1, 0, mk(1, 1, 'h200 + 16*b + 1));
            send(2, 0, mk(1, 1, 'h200 + 16*b + 2));
            send(3, 0, mk(1, 1, 'h200 + 16*b + 3));
            tick(); ivalid = '0;
            for (int i = 1; i <= 3; i++) begin
                tick();
                chk("cont_order", 64'(odata[0 +: DATA_W]), 64'(mk(1, 1, 'h200 + 16*b + i)));
            end
        end
        tick();

        // Backpressure: local VC0 stalled, six flits streamed into port 2 VC0.
        irdy[0] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send(2, 0, mk(1, 1, 'h400 + i)); tick();
            if (i < 4)  chk("bp_ordy_up",   64'(ordy[4]), 64'(1));
            if (i == 4) chk("bp_ordy_fall", 64'(ordy[4]), 64'(0));
            if (i == 5) chk("bp_drop",      64'(odrop[2]), 64'(1));
        end
        ivalid = '0;
        chk("bp_head", 64'(odata[0 +: DATA_W]), 64'(mk(1, 1, 'h400)));
        irdy[0] = 1'b1;
        for (int i = 1; i < 5; i++) begin
            tick();
            chk("bp_drain", 64'(odata[0 +: DATA_W]), 64'(mk(1, 1, 'h400 + i)));
        end
        tick();
        chk("bp_empty", 64'(ovalid[0]), 64'(0));

        // VC independence: port 1 VC0 full and stalled, VC1 keeps flowing east.
        irdy[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(1, 0, mk(1, 1, 'h500 + i)); tick();
        end
        ivalid = '0;
        chk("vci_vc0_full", 64'(ordy[2]), 64'(0));
        chk("vci_vc1_rdy",  64'(ordy[3]), 64'(1));
        for (int i = 0; i < 3; i++) begin
            send(1, 1, mk(2, 1, 'h600 + i)); tick();
            chk("vci_vc1_rdy_run", 64'(ordy[3]), 64'(1));
        end
        ivalid = '0; tick();
        chk("vci_vc1_out", 64'(odata[2*DATA_W +: DATA_W]), 64'(mk(2, 1, 'h602)));
        chk("vci_vc1_ovch", 64'(ovch[2*VCW +: VCW]), 64'(1));
        irdy[0] = 1'b1;
        repeat (8) tick();

        // Wrap-around: 3*DEPTH back-to-back flits through port 0 VC0.
        for (int i = 0; i < 3*DEPTH; i++) begin
            send(0, 0, mk(3, 0, 'h700 + i)); tick();
            chk("wrap_ordy",   64'(ordy[0]),  64'(1));
            chk("wrap_nodrop", 64'(odrop[0]), 64'(0));
        end
        ivalid = '0;
        repeat (3) tick();

        // Random traffic, async reset in the middle of it, then more traffic.
        repeat (800) rand_cycle();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_ovalid", 64'(ovalid), 64'(0));
        chk("async_rst_odrop",  64'(odrop),  64'(0));
        @(negedge clk);
        tick(); tick();
        rst = 1'b0;
        chk("post_rst_ordy", 64'(ordy), 64'({NQ{1'b1}}));
        repeat (800) rand_cycle();

        ivalid = '0;
        irdy   = '1;
        repeat (20) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
